// File: rtl/run_sequencer.sv
// run_sequencer
// Program-run controller for the single-cycle 9-bit-instruction core.
// Turns the top-level start/done handshake into core reset and clock-enable
// sequencing, counts executed RUN cycles, aborts runaway programs with a
// timeout, and arbitrates the single data-memory port between the core and
// the host test harness.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start               level request: high = (re)start, run begins after it falls
//   done, timeout       registered run status (valid in DONE)
//   core_rst, core_en   core reset / advance enable, decoded from registered state
//   halt_req            current instruction is the halt instruction
//   cycle_count         RUN cycles executed in the current/last run
//   core_mem_*          core-side memory request
//   host_mem_*          host-side memory request; host_mem_gnt = host owns port
//   mem_*               arbitrated port to dat_mem
module run_sequencer #(
  parameter int          CLR_CYCLES = 2,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF,
  parameter int          AW         = 8,
  parameter int          DW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic          timeout,
  output logic          core_rst,
  output logic          core_en,
  input  logic          halt_req,
  output logic [15:0]   cycle_count,
  input  logic          core_mem_wr_en,
  input  logic [AW-1:0] core_mem_addr,
  input  logic [DW-1:0] core_mem_wdata,
  input  logic          host_mem_req,
  input  logic          host_mem_wr,
  input  logic [AW-1:0] host_mem_addr,
  input  logic [DW-1:0] host_mem_wdata,
  output logic          host_mem_gnt,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Last CLEAR-cycle index (0-based) that satisfies the minimum hold.
  localparam logic [15:0] CLR_LAST = 16'(CLR_CYCLES - 1);
  // cycle_count value during the final allowed RUN cycle.
  localparam logic [15:0] MAX_LAST = MAX_CYCLES - 16'd1;

  state_e      state_q, state_d;
  logic [15:0] clr_cnt_q, clr_cnt_d;
  logic [15:0] cycle_count_q, cycle_count_d;
  logic        timeout_q, timeout_d;
  logic        done_q, done_d;
  logic        core_rst_q, core_rst_d;
  logic        core_en_q, core_en_d;

  logic        clr_met;
  logic        limit_hit;

  assign clr_met   = (clr_cnt_q >= CLR_LAST);
  assign limit_hit = (MAX_CYCLES != 16'd0) && (cycle_count_q == MAX_LAST);

  // Next-state and next-output logic.
  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which is what keeps this block from inferring latches.
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_CLEAR;
          clr_cnt_d     = 16'd0;
          cycle_count_d = 16'd0;
          timeout_d     = 1'b0;
        end
      end

      S_CLEAR: begin
        if (clr_cnt_q != 16'hFFFF) clr_cnt_d = clr_cnt_q + 16'd1;
        // Leave only once start has dropped and the minimum hold is met.
        if (!start && clr_met) state_d = S_RUN;
      end

      S_RUN: begin
        // The current cycle executes, so it is counted even when it ends the run.
        if (cycle_count_q != 16'hFFFF) cycle_count_d = cycle_count_q + 16'd1;
        if (start) begin
          state_d       = S_CLEAR;
          clr_cnt_d     = 16'd0;
          cycle_count_d = 16'd0;
          timeout_d     = 1'b0;
        end else if (halt_req) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (limit_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end

      S_DONE: begin
        if (start) begin
          state_d       = S_CLEAR;
          clr_cnt_d     = 16'd0;
          cycle_count_d = 16'd0;
          timeout_d     = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of the next state's decode, so they are
    // a pure function of the state register with no input-to-output path.
    done_d     = (state_d == S_DONE);
    core_rst_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
    core_en_d  = (state_d == S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      clr_cnt_q     <= 16'd0;
      cycle_count_q <= 16'd0;
      timeout_q     <= 1'b0;
      done_q        <= 1'b0;
      core_rst_q    <= 1'b1;
      core_en_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      done_q        <= done_d;
      core_rst_q    <= core_rst_d;
      core_en_q     <= core_en_d;
    end
  end

  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;
  assign core_rst    = core_rst_q;
  assign core_en     = core_en_q;

  // Memory port arbitration from the state register. The address defaults
  // to the core's so reads stay observable when nobody owns the port; reset
  // kills any grant and write immediately, before the state flops settle.
  always_comb begin
    host_mem_gnt = 1'b0;
    mem_wr_en    = 1'b0;
    mem_addr     = core_mem_addr;
    mem_wdata    = core_mem_wdata;
    if (!reset) begin
      unique case (state_q)
        S_RUN: begin
          mem_wr_en = core_mem_wr_en;
        end
        S_IDLE, S_DONE: begin
          if (host_mem_req) begin
            host_mem_gnt = 1'b1;
            mem_wr_en    = host_mem_wr;
            mem_addr     = host_mem_addr;
            mem_wdata    = host_mem_wdata;
          end
        end
        default: begin
          // CLEAR: port left unowned.
        end
      endcase
    end
  end

endmodule
